fetch_responder: RTL and testbench



---
 rtl/fetch_responder_pkg.sv | 23 ++
 rtl/fetch_req_slot.sv | 41 ++++
 rtl/fetch_responder.sv | 170 +++++++++++++++++
 tb/tb_fetch_responder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_responder_pkg.sv
// rtl/fetch_responder_pkg.sv - selector codes, widths, error byte and FSM encoding for fetch_responder
package fetch_responder_pkg;

  localparam int FR_REG_WIDTH  = 8;
  localparam int FR_ADDR_WIDTH = 16;
  localparam int FR_SEL_WIDTH  = 4;
  localparam int FR_TIMEOUT    = 15;

  localparam logic [FR_SEL_WIDTH-1:0] SELECTOR_MEM = 4'h0;
  localparam logic [FR_SEL_WIDTH-1:0] SELECTOR_X   = 4'h1;
  localparam logic [FR_SEL_WIDTH-1:0] SELECTOR_Y   = 4'h2;
  localparam logic [FR_SEL_WIDTH-1:0] SELECTOR_A   = 4'h3;

  localparam logic [FR_REG_WIDTH-1:0] ERR_BYTE = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REG_RESP = 2'd1,
    ST_MEM_ACC  = 2'd2,
    ST_RESP     = 2'd3
  } fr_state_e;

endpackage

// File: rtl/fetch_req_slot.sv
// rtl/fetch_req_slot.sv - one-entry pending request buffer with full flag and overrun pulse
module fetch_req_slot #(
  parameter int WIDTH = 29
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_drop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_overrun
);

  logic [WIDTH-1:0] r_data;
  logic             r_full;
  logic             r_overrun;

  // A push in the same edge as a pop reuses the entry being freed.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_data    <= '0;
      r_full    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= (i_push && r_full && !i_pop) || i_drop;
      if (i_push && (!r_full || i_pop)) begin
        r_full <= 1'b1;
        r_data <= i_data;
      end else if (i_pop) begin
        r_full <= 1'b0;
      end
    end
  end

  assign o_data    = r_data;
  assign o_full    = r_full;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/fetch_responder.sv
// rtl/fetch_responder.sv - fetch-side responder: register/memory reads, byte writes, one pending slot
module fetch_responder
  import fetch_responder_pkg::*;
#(
  parameter int REG_WIDTH  = FR_REG_WIDTH,
  parameter int ADDR_WIDTH = FR_ADDR_WIDTH,
  parameter int SEL_WIDTH  = FR_SEL_WIDTH,
  parameter int TIMEOUT    = FR_TIMEOUT
) (
  input  logic                  i_phi1,
  input  logic                  i_reset_n,
  input  logic                  i_req,
  input  logic [SEL_WIDTH-1:0]  i_sel,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_wr_en,
  input  logic [REG_WIDTH-1:0]  i_wr_data,
  input  logic [REG_WIDTH-1:0]  i_x_reg,
  input  logic [REG_WIDTH-1:0]  i_y_reg,
  input  logic [REG_WIDTH-1:0]  i_a_reg,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_rd,
  output logic                  o_mem_wr,
  output logic [REG_WIDTH-1:0]  o_mem_wdata,
  input  logic [REG_WIDTH-1:0]  i_mem_rdata,
  input  logic                  i_mem_ready,
  output logic [REG_WIDTH-1:0]  o_data_out,
  output logic                  o_data_valid,
  output logic                  o_busy,
  output logic                  o_overrun,
  output logic                  o_err
);

  localparam int ENTRY_W = 1 + SEL_WIDTH + ADDR_WIDTH + REG_WIDTH;
  localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 1);
  localparam logic [REG_WIDTH-1:0] ERR_DATA = REG_WIDTH'(ERR_BYTE);
  localparam logic [SEL_WIDTH-1:0] SEL_MEM = SEL_WIDTH'(SELECTOR_MEM);
  localparam logic [SEL_WIDTH-1:0] SEL_X   = SEL_WIDTH'(SELECTOR_X);
  localparam logic [SEL_WIDTH-1:0] SEL_Y   = SEL_WIDTH'(SELECTOR_Y);
  localparam logic [SEL_WIDTH-1:0] SEL_A   = SEL_WIDTH'(SELECTOR_A);

  fr_state_e             r_state, w_state_n;
  logic [REG_WIDTH-1:0]  r_data, w_data_n;
  logic                  r_is_write, w_is_write_n;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_n;
  logic [REG_WIDTH-1:0]  r_mem_wdata, w_mem_wdata_n;
  logic [3:0]            r_tmo_cnt, w_tmo_cnt_n;
  logic                  r_err, w_err_n;

  logic                  w_free, w_take_in, w_start, w_pop, w_push, w_drop;
  logic [ENTRY_W-1:0]    w_in_entry, w_start_entry, w_slot_data;
  logic [SEL_WIDTH-1:0]  w_start_sel;
  logic                  w_slot_full, w_slot_overrun;

  // Incoming work starts directly only when the current job ends and nothing is queued.
  assign w_take_in  = w_free && !w_slot_full;
  assign w_push     = w_take_in ? (i_req && i_wr_en) : (i_req || i_wr_en);
  assign w_drop     = !w_take_in && i_req && i_wr_en;
  assign w_in_entry = {!w_take_in && i_wr_en, i_sel, i_addr, i_wr_data};

  fetch_req_slot #(.WIDTH(ENTRY_W)) u_slot (
    .i_clk     (i_phi1),
    .i_reset_n (i_reset_n),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_drop    (w_drop),
    .i_data    (w_in_entry),
    .o_data    (w_slot_data),
    .o_full    (w_slot_full),
    .o_overrun (w_slot_overrun)
  );

  always_comb begin
    w_state_n     = r_state;
    w_data_n      = r_data;
    w_is_write_n  = r_is_write;
    w_mem_addr_n  = r_mem_addr;
    w_mem_wdata_n = r_mem_wdata;
    w_tmo_cnt_n   = r_tmo_cnt;
    w_err_n       = r_err;
    w_free        = 1'b0;
    w_start       = 1'b0;
    w_pop         = 1'b0;
    w_start_entry = '0;
    w_start_sel   = '0;

    case (r_state)
      ST_IDLE, ST_REG_RESP, ST_RESP: w_free = 1'b1;
      ST_MEM_ACC: begin
        if (i_mem_ready || r_tmo_cnt == TMO_LAST) begin
          w_tmo_cnt_n = '0;
          if (!i_mem_ready) w_err_n = 1'b1;
          if (r_is_write) begin
            w_free = 1'b1;
          end else begin
            w_state_n = ST_RESP;
            w_data_n  = i_mem_ready ? i_mem_rdata : ERR_DATA;
          end
        end else begin
          w_tmo_cnt_n = r_tmo_cnt + 4'd1;
        end
      end
      default: w_state_n = ST_IDLE;
    endcase

    if (w_free) begin
      w_state_n = ST_IDLE;
      if (w_slot_full) begin
        w_start       = 1'b1;
        w_pop         = 1'b1;
        w_start_entry = w_slot_data;
      end else if (i_wr_en || i_req) begin
        w_start       = 1'b1;
        w_start_entry = {i_wr_en, i_sel, i_addr, i_wr_data};
      end
    end

    if (w_start) begin
      w_start_sel   = w_start_entry[REG_WIDTH+ADDR_WIDTH +: SEL_WIDTH];
      w_is_write_n  = w_start_entry[ENTRY_W-1];
      w_mem_addr_n  = w_start_entry[REG_WIDTH +: ADDR_WIDTH];
      w_mem_wdata_n = w_start_entry[REG_WIDTH-1:0];
      w_tmo_cnt_n   = '0;
      if (w_start_entry[ENTRY_W-1] || w_start_sel == SEL_MEM) begin
        w_state_n = ST_MEM_ACC;
      end else begin
        w_state_n = ST_REG_RESP;
        case (w_start_sel)
          SEL_X:   w_data_n = i_x_reg;
          SEL_Y:   w_data_n = i_y_reg;
          SEL_A:   w_data_n = i_a_reg;
          default: begin
            w_data_n = ERR_DATA;
            w_err_n  = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge i_phi1) begin
    if (!i_reset_n) begin
      r_state     <= ST_IDLE;
      r_data      <= '0;
      r_is_write  <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_tmo_cnt   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_data      <= w_data_n;
      r_is_write  <= w_is_write_n;
      r_mem_addr  <= w_mem_addr_n;
      r_mem_wdata <= w_mem_wdata_n;
      r_tmo_cnt   <= w_tmo_cnt_n;
      r_err       <= w_err_n;
    end
  end

  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_mem_rd     = (r_state == ST_MEM_ACC) && !r_is_write;
  assign o_mem_wr     = (r_state == ST_MEM_ACC) && r_is_write;
  assign o_data_out   = r_data;
  assign o_data_valid = (r_state == ST_REG_RESP) || (r_state == ST_RESP);
  assign o_busy       = (r_state != ST_IDLE);
  assign o_overrun    = w_slot_overrun;
  assign o_err        = r_err;

endmodule

// File: tb/tb_fetch_responder.sv
// tb/tb_fetch_responder.sv - directed and randomized bench for fetch_responder against a job/queue model
module tb_fetch_responder;
  import fetch_responder_pkg::*;

  logic        phi1 = 1'b0;
  logic        reset_n, req, wr_en, mem_ready;
  logic [3:0]  sel;
  logic [15:0] addr;
  logic [7:0]  wr_data, x_reg, y_reg, a_reg, mem_rdata;
  logic [15:0] o_mem_addr;
  logic        o_mem_rd, o_mem_wr, o_data_valid, o_busy, o_overrun, o_err;
  logic [7:0]  o_mem_wdata, o_data_out;

  always #5 phi1 = ~phi1;

  fetch_responder dut (
    .i_phi1(phi1), .i_reset_n(reset_n), .i_req(req), .i_sel(sel), .i_addr(addr),
    .i_wr_en(wr_en), .i_wr_data(wr_data), .i_x_reg(x_reg), .i_y_reg(y_reg), .i_a_reg(a_reg),
    .o_mem_addr(o_mem_addr), .o_mem_rd(o_mem_rd), .o_mem_wr(o_mem_wr), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(mem_rdata), .i_mem_ready(mem_ready), .o_data_out(o_data_out),
    .o_data_valid(o_data_valid), .o_busy(o_busy), .o_overrun(o_overrun), .o_err(o_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: a job in flight, a FIFO of at most one waiting job, and the external memory contents.
  typedef struct packed {
    logic        is_write;
    logic [3:0]  sel;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } job_t;

  job_t       q[$];
  job_t       m_job;
  int         m_kind;   // 0 nothing in memory, 1 read in memory, 2 write in memory
  int         m_waits;
  bit         m_resp, m_err, m_ovr, m_was_reset;
  logic [7:0] m_data;
  logic [7:0] mem_model [logic [15:0]];

  function automatic logic [7:0] mem_read(input logic [15:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  task automatic begin_job(input job_t j);
    m_job   = j;
    m_waits = 0;
    if (j.is_write) m_kind = 2;
    else case (j.sel)
      4'd0: m_kind = 1;
      4'd1: begin m_resp = 1; m_data = x_reg; end
      4'd2: begin m_resp = 1; m_data = y_reg; end
      4'd3: begin m_resp = 1; m_data = a_reg; end
      default: begin m_resp = 1; m_data = 8'hFF; m_err = 1; end
    endcase
  endtask

  task automatic model_edge();
    bit   free, done;
    job_t wr, rd;
    m_ovr = 0;
    m_was_reset = !reset_n;
    if (!reset_n) begin
      q.delete();
      m_kind = 0; m_resp = 0; m_data = 8'h00; m_err = 0; m_waits = 0;
      return;
    end
    free = m_resp || (m_kind == 0);
    m_resp = 0;
    if (m_kind != 0) begin
      done = mem_ready;
      if (!mem_ready) begin
        m_waits++;
        if (m_waits == FR_TIMEOUT) begin done = 1; m_err = 1; end
      end
      if (done) begin
        if (m_kind == 1) begin
          m_resp = 1;
          m_data = mem_ready ? mem_read(m_job.addr) : 8'hFF;
        end else begin
          if (mem_ready) mem_model[m_job.addr] = m_job.wdata;
          free = 1;
        end
        m_kind = 0;
      end
    end
    wr = {1'b1, sel, addr, wr_data};
    rd = {1'b0, sel, addr, wr_data};
    if (free && q.size() == 0) begin
      if (wr_en) begin
        begin_job(wr);
        if (req) q.push_back(rd);
      end else if (req) begin
        begin_job(rd);
      end
    end else begin
      if (free) begin_job(q.pop_front());
      if (wr_en || req) begin
        if (q.size() == 0) q.push_back(wr_en ? wr : rd);
        else m_ovr = 1;
        if (wr_en && req) m_ovr = 1;
      end
    end
  endtask

  task automatic compare_model();
    check("data_valid", o_data_valid, m_resp);
    check("data_out", o_data_out, m_data);
    check("busy", o_busy, m_resp || m_kind != 0);
    check("mem_rd", o_mem_rd, m_kind == 1);
    check("mem_wr", o_mem_wr, m_kind == 2);
    check("overrun", o_overrun, m_ovr);
    check("err", o_err, m_err);
    if (m_kind != 0) check("mem_addr", o_mem_addr, m_job.addr);
    if (m_kind == 2) check("mem_wdata", o_mem_wdata, m_job.wdata);
    if (m_was_reset) begin
      check("rst_mem_addr", o_mem_addr, 0);
      check("rst_mem_wdata", o_mem_wdata, 0);
    end
  endtask

  task automatic step();
    @(posedge phi1);
    model_edge();
    #1;
    compare_model();
    mem_rdata = mem_read(m_job.addr);
  endtask

  int  n_valid, n_ovr, n_rd, stall;
  bit  seen;

  initial begin
    reset_n = 0; req = 0; wr_en = 0; sel = '0; addr = '0; wr_data = '0;
    x_reg = '0; y_reg = '0; a_reg = '0; mem_ready = 0; mem_rdata = '0;
    m_job = '0; m_kind = 0;
    repeat (2) step();
    reset_n = 1;
    step();

    // reset abandons a stalled memory read
    req = 1; sel = SELECTOR_MEM; addr = 16'h1234;
    step();
    req = 0;
    repeat (3) step();
    reset_n = 0;
    step();
    check("rst_mid_busy", o_busy, 0);
    check("rst_mid_mem_rd", o_mem_rd, 0);
    check("rst_mid_err", o_err, 0);
    check("rst_mid_valid", o_data_valid, 0);
    reset_n = 1;

    // register read captured at the req edge
    x_reg = 8'h3C; sel = SELECTOR_X; req = 1;
    step();
    req = 0; x_reg = 8'h99;
    check("x_valid", o_data_valid, 1);
    check("x_data", o_data_out, 8'h3C);
    step();
    check("x_hold", o_data_out, 8'h3C);

    // memory read with two wait cycles
    mem_model[16'h0200] = 8'hA9;
    req = 1; sel = SELECTOR_MEM; addr = 16'h0200; mem_ready = 0;
    step();
    req = 0;
    check("mrd_addr", o_mem_addr, 16'h0200);
    repeat (2) step();
    mem_ready = 1;
    n_valid = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      mem_ready = 0;
      if (i == 0) begin
        check("mrd_data", o_data_out, 8'hA9);
        check("mrd_rd_low", o_mem_rd, 0);
      end
      if (o_data_valid) n_valid++;
    end
    check("mrd_valid_once", n_valid, 1);

    // write and same-cycle register read: write goes first
    y_reg = 8'h07; wr_en = 1; addr = 16'h00F0; wr_data = 8'h55; req = 1; sel = SELECTOR_Y;
    step();
    wr_en = 0; req = 0;
    check("wr_mem_wr", o_mem_wr, 1);
    check("wr_wdata", o_mem_wdata, 8'h55);
    mem_ready = 1;
    step();
    mem_ready = 0;
    check("wr_then_y", o_data_out, 8'h07);
    check("wr_then_y_valid", o_data_valid, 1);
    check("wr_no_ovr", o_overrun, 0);
    step();

    // three back-to-back reads while the first stalls
    n_valid = 0; n_ovr = 0;
    req = 1; sel = SELECTOR_MEM;
    for (int i = 0; i < 3; i++) begin
      addr = 16'h0300 + 16'(i);
      step();
      n_valid += int'(o_data_valid); n_ovr += int'(o_overrun);
    end
    req = 0; mem_ready = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_valid += int'(o_data_valid); n_ovr += int'(o_overrun);
    end
    mem_ready = 0;
    check("b2b_valids", n_valid, 2);
    check("b2b_overruns", n_ovr, 1);

    // memory never answers
    req = 1; sel = SELECTOR_MEM; addr = 16'h0400;
    step();
    req = 0;
    n_rd = int'(o_mem_rd); seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (o_mem_rd) n_rd++;
      if (o_data_valid) seen = 1;
    end
    check("tmo_seen", seen, 1);
    check("tmo_cycles", n_rd, 15);
    check("tmo_err", o_err, 1);
    check("tmo_data", o_data_out, 8'hFF);
    repeat (5) step();
    check("tmo_err_sticky", o_err, 1);
    reset_n = 0;
    step();
    check("tmo_err_cleared", o_err, 0);
    reset_n = 1;

    // randomized traffic
    stall = 0;
    for (int i = 0; i < 4000; i++) begin
      reset_n = ($urandom_range(0, 199) != 0);
      req     = ($urandom_range(0, 9) < 3);
      wr_en   = ($urandom_range(0, 9) < 2);
      sel     = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      addr    = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 31));
      wr_data = 8'($urandom);
      x_reg   = 8'($urandom);
      y_reg   = 8'($urandom);
      a_reg   = 8'($urandom);
      if (stall > 0) begin
        mem_ready = 0;
        stall--;
      end else begin
        if ($urandom_range(0, 49) == 0) stall = 18;
        mem_ready = 1'($urandom_range(0, 1));
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
